baud_cfg_ctrl: RTL and testbench

Configuration sequencer for the UART baud rate generator. Software writes shadow baud_freq/baud_limit values over a simple register port, then issues an apply command. The block waits for the UART to go idle, validates the values, holds the generator in reset while it loads them, and confirms that ce_16 restarts. It sits between the peripheral register bus and baud_gen, and it alone drives baud_gen's baud_freq, baud_limit and its local reset.

---
 rtl/baud_cfg_ctrl.sv | 165 ++++++++++++++++
 tb/tb_baud_cfg_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_cfg_ctrl.sv
// Baud rate configuration sequencer: shadows software writes, drains the UART,
// holds baud_gen in reset while new values load, then confirms ce_16 restarts.
module baud_cfg_ctrl #(
    parameter int unsigned DEF_FREQ      = 576,
    parameter int unsigned DEF_LIMIT     = 15049,
    parameter int unsigned RST_CYCLES    = 4,
    parameter int unsigned DRAIN_TIMEOUT = 65535,
    parameter int unsigned TICK_TIMEOUT  = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data,
    input  logic        uart_busy,
    input  logic        ce_16,
    output logic [11:0] baud_freq,
    output logic [15:0] baud_limit,
    output logic        baud_rst,
    output logic        cfg_busy,
    output logic        cfg_done
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHECK     = 3'd1;
    localparam logic [2:0] DRAIN     = 3'd2;
    localparam logic [2:0] HOLD      = 3'd3;
    localparam logic [2:0] WAIT_TICK = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [11:0] DEF_F   = 12'(DEF_FREQ);
    localparam logic [15:0] DEF_L   = 16'(DEF_LIMIT);
    localparam logic [15:0] RST_C   = 16'(RST_CYCLES);
    localparam logic [15:0] DRAIN_T = 16'(DRAIN_TIMEOUT);
    localparam logic [15:0] TICK_T  = 16'(TICK_TIMEOUT);

    logic [2:0]  state;
    logic [11:0] shadow_freq;
    logic [15:0] shadow_limit;
    logic [11:0] pend_freq;
    logic [15:0] pend_limit;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        param_err;
    logic        drain_err;
    logic        tick_err;
    logic        wr_ctl;
    logic        apply;
    logic        err_clr;

    assign wr_ctl   = wr_en && (wr_addr == 2'd2);
    assign apply    = wr_ctl && wr_data[0];
    assign err_clr  = wr_ctl && wr_data[1];
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign cfg_busy = (state != IDLE);
    assign cfg_done = (state == DONE);

    // Shadow registers take software writes in any state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_freq  <= DEF_F;
            shadow_limit <= DEF_L;
        end else if (wr_en) begin
            if (wr_addr == 2'd0) shadow_freq  <= wr_data[11:0];
            if (wr_addr == 2'd1) shadow_limit <= wr_data;
        end
    end

    // Update sequence; a clear lands before any error set in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pend_freq  <= DEF_F;
            pend_limit <= DEF_L;
            cnt        <= '0;
            baud_freq  <= DEF_F;
            baud_limit <= DEF_L;
            baud_rst   <= 1'b0;
            param_err  <= 1'b0;
            drain_err  <= 1'b0;
            tick_err   <= 1'b0;
        end else begin
            if (err_clr) begin
                param_err <= 1'b0;
                drain_err <= 1'b0;
                tick_err  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (apply) begin
                        pend_freq  <= shadow_freq;
                        pend_limit <= shadow_limit;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (pend_freq == '0 || pend_limit == '0) begin
                        param_err <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt   <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!uart_busy) begin
                        baud_freq  <= pend_freq;
                        baud_limit <= pend_limit;
                        baud_rst   <= 1'b1;
                        cnt        <= 16'd1;
                        state      <= HOLD;
                    end else if (cnt_inc >= DRAIN_T) begin
                        drain_err <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HOLD: begin
                    if (cnt >= RST_C) begin
                        baud_rst <= 1'b0;
                        cnt      <= '0;
                        state    <= WAIT_TICK;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_TICK: begin
                    if (ce_16) begin
                        state <= DONE;
                    end else if (cnt_inc >= TICK_T) begin
                        tick_err <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered read mux, one cycle behind rd_addr
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            case (rd_addr)
                2'd0:    rd_data <= {4'b0, shadow_freq};
                2'd1:    rd_data <= shadow_limit;
                2'd2:    rd_data <= {12'b0, tick_err, drain_err,
                                     param_err, cfg_busy};
                default: rd_data <= {4'b0, baud_freq};
            endcase
        end
    end

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// Directed bench for baud_cfg_ctrl with a small baud_gen tick model.
// Inputs change and outputs are sampled on the falling edge.
module tb_baud_cfg_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        uart_busy = 1'b0;
    logic        ce_16 = 1'b0;
    logic [11:0] baud_freq;
    logic [15:0] baud_limit;
    logic        baud_rst;
    logic        cfg_busy;
    logic        cfg_done;

    int          n_chk = 0;
    int          n_fail = 0;
    logic        tick_en = 1'b1;
    logic [3:0]  tcnt = '0;

    baud_cfg_ctrl #(
        .DEF_FREQ(576),
        .DEF_LIMIT(15049),
        .RST_CYCLES(4),
        .DRAIN_TIMEOUT(16),
        .TICK_TIMEOUT(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .uart_busy(uart_busy),
        .ce_16(ce_16),
        .baud_freq(baud_freq),
        .baud_limit(baud_limit),
        .baud_rst(baud_rst),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done)
    );

    always #5 clock = ~clock;

    // baud_gen stand-in: tick every 8 cycles once out of its reset
    always @(posedge clock or posedge reset) begin
        if (reset || baud_rst || !tick_en) begin
            tcnt  <= '0;
            ce_16 <= 1'b0;
        end else begin
            tcnt  <= tcnt + 4'd1;
            ce_16 <= (tcnt == 4'd7);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        @(negedge clock);
        rd_addr = a;
        @(negedge clock);
        d = rd_data;
    endtask

    // Sample index i is the falling edge after the i-th rising edge
    // following the apply write.
    task automatic mon(input int max, output int rst_hi, output int done_n,
                       output int done_at, output int fall_at,
                       output logic [11:0] f_rst);
        logic prev;
        prev    = 1'b0;
        rst_hi  = 0;
        done_n  = 0;
        done_at = -1;
        fall_at = -1;
        f_rst   = '0;
        for (int i = 1; i <= max; i++) begin
            if (baud_rst) begin
                if (rst_hi == 0) f_rst = baud_freq;
                rst_hi++;
            end
            if (!baud_rst && prev && fall_at < 0) fall_at = i;
            prev = baud_rst;
            if (cfg_done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (done_at > 0 && i >= done_at + 2) break;
            @(negedge clock);
        end
        check("seq_end", 32'(done_at > 0), 32'd1);
    endtask

    initial begin
        logic [15:0] d;
        logic [11:0] fr;
        int rh, dn, da, fa;

        repeat (3) @(negedge clock);
        check("rst_freq_in", 32'(baud_freq), 32'd576);
        reset = 1'b0;
        check("rst_freq", 32'(baud_freq), 32'd576);
        check("rst_limit", 32'(baud_limit), 32'd15049);
        check("rst_brst", 32'(baud_rst), 32'd0);
        check("rst_busy", 32'(cfg_busy), 32'd0);
        check("rst_done", 32'(cfg_done), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        rd(2'd2, d);
        check("rst_stat", 32'(d), 32'h0000);
        rd(2'd0, d);
        check("rst_shf", 32'(d), 32'd576);
        rd(2'd1, d);
        check("rst_shl", 32'(d), 32'd15049);

        // normal update
        wr(2'd0, 16'h0120);
        wr(2'd1, 16'h3A98);
        wr(2'd2, 16'h0001);
        mon(200, rh, dn, da, fa, fr);
        check("ok_rst_len", 32'(rh), 32'd4);
        check("ok_rst_freq", 32'(fr), 32'h120);
        check("ok_fall", 32'(fa), 32'd7);
        check("ok_done_n", 32'(dn), 32'd1);
        check("ok_freq", 32'(baud_freq), 32'h120);
        check("ok_limit", 32'(baud_limit), 32'h3A98);
        rd(2'd3, d);
        check("ok_rd3", 32'(d), 32'h0120);
        rd(2'd2, d);
        check("ok_stat", 32'(d), 32'h0000);

        // zero freq rejected
        wr(2'd0, 16'h0000);
        wr(2'd2, 16'h0001);
        mon(50, rh, dn, da, fa, fr);
        check("perr_done_at", 32'(da), 32'd2);
        check("perr_rst", 32'(rh), 32'd0);
        check("perr_done_n", 32'(dn), 32'd1);
        check("perr_freq", 32'(baud_freq), 32'h120);
        check("perr_limit", 32'(baud_limit), 32'h3A98);
        rd(2'd2, d);
        check("perr_stat", 32'(d), 32'h0002);
        wr(2'd2, 16'h0002);
        rd(2'd2, d);
        check("perr_clr", 32'(d), 32'h0000);

        // drain timeout then a good retry
        wr(2'd0, 16'h00A0);
        uart_busy = 1'b1;
        wr(2'd2, 16'h0001);
        mon(100, rh, dn, da, fa, fr);
        check("derr_done_at", 32'(da), 32'd18);
        check("derr_rst", 32'(rh), 32'd0);
        check("derr_freq", 32'(baud_freq), 32'h120);
        rd(2'd2, d);
        check("derr_stat", 32'(d), 32'h0004);
        uart_busy = 1'b0;
        wr(2'd2, 16'h0001);
        mon(200, rh, dn, da, fa, fr);
        check("retry_rst", 32'(rh), 32'd4);
        check("retry_freq", 32'(baud_freq), 32'h0A0);
        rd(2'd2, d);
        check("retry_stat", 32'(d), 32'h0004);
        wr(2'd2, 16'h0002);
        rd(2'd2, d);
        check("derr_clr", 32'(d), 32'h0000);

        // no tick from baud_gen
        tick_en = 1'b0;
        wr(2'd0, 16'h00B0);
        wr(2'd2, 16'h0001);
        mon(300, rh, dn, da, fa, fr);
        check("terr_gap", 32'(da - fa), 32'd64);
        check("terr_freq", 32'(baud_freq), 32'h0B0);
        check("terr_limit", 32'(baud_limit), 32'h3A98);
        rd(2'd2, d);
        check("terr_stat", 32'(d), 32'h0008);
        tick_en = 1'b1;
        wr(2'd2, 16'h0003);
        mon(200, rh, dn, da, fa, fr);
        check("clrapp_rst", 32'(rh), 32'd4);
        check("clrapp_done", 32'(dn), 32'd1);
        rd(2'd2, d);
        check("clrapp_stat", 32'(d), 32'h0000);

        // addr 3 writes ignored
        wr(2'd3, 16'hFFFF);
        rd(2'd3, d);
        check("a3_rd3", 32'(d), 32'h00B0);
        rd(2'd0, d);
        check("a3_rd0", 32'(d), 32'h00B0);

        // apply during DRAIN is dropped
        uart_busy = 1'b1;
        wr(2'd2, 16'h0001);
        repeat (3) @(negedge clock);
        wr(2'd0, 16'h0055);
        wr(2'd2, 16'h0001);
        mon(100, rh, dn, da, fa, fr);
        check("dup_done_n", 32'(dn), 32'd1);
        check("dup_busy", 32'(cfg_busy), 32'd0);
        check("dup_freq", 32'(baud_freq), 32'h0B0);
        rd(2'd0, d);
        check("dup_shadow", 32'(d), 32'h0055);
        wr(2'd2, 16'h0002);

        // reset in HOLD
        uart_busy = 1'b0;
        wr(2'd1, 16'h1234);
        wr(2'd2, 16'h0001);
        for (int k = 0; k < 20 && !baud_rst; k++) @(negedge clock);
        check("hold_seen", 32'(baud_rst), 32'd1);
        check("hold_freq", 32'(baud_freq), 32'h055);
        reset = 1'b1;
        #1;
        check("mrst_freq", 32'(baud_freq), 32'd576);
        check("mrst_limit", 32'(baud_limit), 32'd15049);
        check("mrst_brst", 32'(baud_rst), 32'd0);
        check("mrst_busy", 32'(cfg_busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rd(2'd0, d);
        check("mrst_shf", 32'(d), 32'd576);
        rd(2'd2, d);
        check("mrst_stat", 32'(d), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
